perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 119 +++++++++++
 tb/tb_perf_counter_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - per-channel event counters, halt-aware cycle counter,
// snapshot shadows with registered readback
module perf_counter_bank #(
  parameter int NCH = 8,
  parameter int CW  = 32,
  parameter int SAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     halt,
  input  logic                     stall,
  input  logic [NCH-1:0]           evt,
  input  logic                     clr,
  input  logic [NCH-1:0]           clr_mask,
  input  logic                     snap,
  input  logic [$clog2(NCH+1)-1:0] rd_sel,
  output logic [CW-1:0]            rd_data,
  output logic [CW-1:0]            cycles,
  output logic [NCH-1:0]           ovf
);

  localparam int SW = $clog2(NCH + 1);

  logic [CW-1:0] cnt    [NCH];
  logic [CW-1:0] shadow [NCH+1];
  logic [CW-1:0] cnt_next [NCH];
  logic [NCH-1:0] ovf_next;
  logic [CW-1:0] cycles_next;
  logic          halt_once;
  logic          halt_once_next;
  logic [CW-1:0] rd_next;

  // Clear wins over a same-cycle increment; in SAT mode an all-ones counter simply holds.
  always_comb begin
    ovf_next = ovf;
    for (int i = 0; i < NCH; i++) begin
      cnt_next[i] = cnt[i];
      if (clr && clr_mask[i]) begin
        cnt_next[i] = '0;
        ovf_next[i] = 1'b0;
      end else if (en && evt[i]) begin
        if (&cnt[i]) begin
          ovf_next[i] = 1'b1;
          if (SAT == 0) begin
            cnt_next[i] = '0;
          end
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // While halted the counter advances only on the first non-stalled halted cycle.
  always_comb begin
    cycles_next    = cycles;
    halt_once_next = halt_once;
    if (!stall) begin
      if (!halt) begin
        cycles_next    = cycles + CW'(1);
        halt_once_next = 1'b0;
      end else if (!halt_once) begin
        cycles_next    = cycles + CW'(1);
        halt_once_next = 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    if (rd_sel <= SW'(NCH)) begin
      rd_next = shadow[rd_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      ovf <= ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles    <= '0;
      halt_once <= 1'b0;
    end else begin
      cycles    <= cycles_next;
      halt_once <= halt_once_next;
    end
  end

  // Shadows capture pre-edge values, so snap with clr still keeps the old count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NCH; i++) begin
        shadow[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (snap) begin
        for (int i = 0; i < NCH; i++) begin
          shadow[i] <= cnt[i];
        end
        shadow[NCH] <= cycles;
      end
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed scenarios plus randomized run against a reference model
module tb_perf_counter_bank;

  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int MOD = 256;

  logic clk = 1'b0;
  logic rst, en, halt, stall, clr, snap;
  logic [NCH-1:0] evt, clr_mask;
  logic [3:0] rd_sel;
  logic [CW-1:0] rd_data [2];
  logic [CW-1:0] cycles [2];
  logic [NCH-1:0] ovf [2];

  int total = 0;
  int bad = 0;

  int unsigned mcnt [2][NCH];
  bit          movf [2][NCH];
  int unsigned msh  [2][NCH+1];
  int unsigned mrd  [2];
  int unsigned mcyc;
  bit          mhalted;

  always #5 clk = ~clk;

  perf_counter_bank #(.NCH(NCH), .CW(CW), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .stall(stall), .evt(evt),
    .clr(clr), .clr_mask(clr_mask), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_data[0]), .cycles(cycles[0]), .ovf(ovf[0])
  );

  perf_counter_bank #(.NCH(NCH), .CW(CW), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .stall(stall), .evt(evt),
    .clr(clr), .clr_mask(clr_mask), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_data[1]), .cycles(cycles[1]), .ovf(ovf[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: counts as plain integers reduced modulo 2^CW.
  task automatic model_step();
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NCH; i++) begin
          mcnt[s][i] = 0;
          movf[s][i] = 0;
        end
        for (int i = 0; i <= NCH; i++) msh[s][i] = 0;
        mrd[s] = 0;
      end
      mcyc = 0;
      mhalted = 0;
      return;
    end
    for (int s = 0; s < 2; s++) begin
      mrd[s] = (int'(rd_sel) <= NCH) ? msh[s][rd_sel] : 0;
      if (snap) begin
        for (int i = 0; i < NCH; i++) msh[s][i] = mcnt[s][i];
        msh[s][NCH] = mcyc;
      end
      for (int i = 0; i < NCH; i++) begin
        if (clr && clr_mask[i]) begin
          mcnt[s][i] = 0;
          movf[s][i] = 0;
        end else if (en && evt[i]) begin
          if (mcnt[s][i] == MOD - 1) begin
            movf[s][i] = 1;
            mcnt[s][i] = (s == 1) ? MOD - 1 : 0;
          end else begin
            mcnt[s][i] = mcnt[s][i] + 1;
          end
        end
      end
    end
    if (!stall) begin
      if (!halt) begin
        mcyc = (mcyc + 1) % MOD;
        mhalted = 0;
      end else if (!mhalted) begin
        mcyc = (mcyc + 1) % MOD;
        mhalted = 1;
      end
    end
  endtask

  task automatic compare_model();
    logic [NCH-1:0] eo;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NCH; i++) eo[i] = movf[s][i];
      chk($sformatf("model.cycles[%0d]", s), 64'(cycles[s]), 64'(mcyc));
      chk($sformatf("model.ovf[%0d]", s), 64'(ovf[s]), 64'(eo));
      chk($sformatf("model.rd_data[%0d]", s), 64'(rd_data[s]), 64'(mrd[s]));
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_model();
      @(negedge clk);
    end
  endtask

  task automatic idle();
    rst = 0; en = 0; halt = 0; stall = 0; clr = 0; snap = 0;
    evt = '0; clr_mask = '0; rd_sel = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    for (int s = 0; s < 2; s++) begin
      chk("reset.cycles", 64'(cycles[s]), 64'd0);
      chk("reset.ovf", 64'(ovf[s]), 64'd0);
      chk("reset.rd_data", 64'(rd_data[s]), 64'd0);
    end

    // run then halt: one extra count on the first halted cycle
    tick(10);
    halt = 1;
    tick(5);
    chk("halt_once.cycles", 64'(cycles[0]), 64'd11);

    // stalled halt does not consume the halt-once count
    do_reset();
    tick(3);
    halt = 1; stall = 1;
    tick(4);
    stall = 0;
    tick(2);
    chk("stall_halt.cycles", 64'(cycles[1]), 64'd4);

    // 257 increments on an 8-bit channel
    do_reset();
    en = 1; evt = 8'h01;
    tick(257);
    en = 0; evt = '0; snap = 1; rd_sel = 4'd0;
    tick();
    snap = 0;
    tick();
    chk("wrap.ch0", 64'(rd_data[0]), 64'd1);
    chk("wrap.ovf0", 64'(ovf[0][0]), 64'd1);
    chk("sat.ch0", 64'(rd_data[1]), 64'd255);
    chk("sat.ovf0", 64'(ovf[1][0]), 64'd1);

    // clear + snap + event on the same cycle
    do_reset();
    en = 1; evt = 8'h04;
    tick(7);
    clr = 1; clr_mask = 8'h04; snap = 1; rd_sel = 4'd2;
    tick();
    clr = 0; clr_mask = '0; snap = 0; en = 0; evt = '0;
    tick();
    chk("clr_snap.shadow2", 64'(rd_data[0]), 64'd7);
    chk("clr_snap.ovf2", 64'(ovf[0][2]), 64'd0);
    snap = 1;
    tick();
    snap = 0;
    tick();
    chk("clr_snap.ch2", 64'(rd_data[1]), 64'd0);

    // en low blocks events; cycle counter keeps running
    do_reset();
    en = 0; evt = 8'hFF;
    tick(20);
    chk("en_low.cycles", 64'(cycles[0]), 64'd20);
    snap = 1; rd_sel = 4'd9;
    tick();
    snap = 0;
    tick();
    chk("rd_sel_oob.rd_data", 64'(rd_data[0]), 64'd0);
    rd_sel = 4'd5;
    tick();
    chk("en_low.ch5", 64'(rd_data[1]), 64'd0);

    // reset in the middle of a halt
    do_reset();
    en = 1; evt = 8'hFF;
    tick(5);
    halt = 1; snap = 1; rd_sel = 4'd8;
    tick(3);
    snap = 0;
    rst = 1;
    tick();
    chk("mid_halt_rst.cycles", 64'(cycles[0]), 64'd0);
    chk("mid_halt_rst.ovf", 64'(ovf[0]), 64'd0);
    chk("mid_halt_rst.rd_data", 64'(rd_data[0]), 64'd0);
    rst = 0; en = 0; evt = '0;
    tick();
    chk("mid_halt_rst.first_halt", 64'(cycles[1]), 64'd1);
    tick(2);
    chk("mid_halt_rst.hold", 64'(cycles[1]), 64'd1);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      evt      = NCH'($urandom);
      clr      = ($urandom_range(0, 39) == 0);
      clr_mask = NCH'($urandom);
      snap     = ($urandom_range(0, 7) == 0);
      rd_sel   = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
